multicycle_control: RTL and testbench

Main control FSM for the multicycle CPU datapath. Sequences each instruction through fetch, decode, execute, memory and write-back states, driving every datapath enable and mux select. Sits directly upstream of the ALU control decoder and supplies its 2-bit `ALUOp`. Stalls on memory accesses via a ready handshake.

---
 rtl/multicycle_control.sv | 147 ++++++++++++++
 tb/tb_multicycle_control.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle CPU datapath: sequences each instruction
// through fetch/decode/execute/memory/write-back and drives every datapath control.
module multicycle_control (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] Op,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       ALUSrcA,
   output logic [1:0] PCSource,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [3:0] state,
   output logic       illegal_op
);

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_J     = 6'd2;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RCOMP  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9
   } state_e;

   state_e state_q, state_d;

   // NOTE: sequential state uses non-blocking assignment so every flop samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   assign state = state_q;

   always_comb begin
      // NOTE: every output and state_d gets a default before the case so no path
      // leaves a signal unassigned, which would otherwise infer a latch.
      state_d     = S_FETCH;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      ALUSrcA     = 1'b0;
      PCSource    = 2'b00;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      illegal_op  = 1'b0;

      // While reset is held every control stays at 0, whatever state is current.
      if (rst_n) begin
         case (state_q)
            S_FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               IRWrite = mem_ready;
               PCWrite = mem_ready;
               state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
               ALUSrcB = 2'b11;
               case (Op)
                  OP_LW, OP_SW: state_d = S_MEMADR;
                  OP_RTYPE:     state_d = S_EXEC;
                  OP_BEQ:       state_d = S_BRANCH;
                  OP_J:         state_d = S_JUMP;
                  default: begin
                     illegal_op = 1'b1;
                     state_d    = S_FETCH;
                  end
               endcase
            end
            S_MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
               state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
               state_d  = S_FETCH;
            end
            S_MEMWR: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
               state_d  = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
               ALUSrcA = 1'b1;
               ALUOp   = 2'b10;
               state_d = S_RCOMP;
            end
            S_RCOMP: begin
               RegWrite = 1'b1;
               RegDst   = 1'b1;
               state_d  = S_FETCH;
            end
            S_BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUOp       = 2'b01;
               PCWriteCond = 1'b1;
               PCSource    = 2'b01;
               state_d     = S_FETCH;
            end
            S_JUMP: begin
               PCWrite  = 1'b1;
               PCSource = 2'b10;
               state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;  // unreachable encodings recover silently
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus random
// instruction streams checked against a per-instruction state-plan model.
module tb_multicycle_control;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_J     = 6'd2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] Op;
   logic       mem_ready;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
   logic       IRWrite, RegWrite, RegDst, ALUSrcA, illegal_op;
   logic [1:0] PCSource, ALUSrcB, ALUOp;
   logic [3:0] state;
   logic [16:0] ctrl_obs;

   int n_cmp = 0;
   int n_mis = 0;

   // Remaining states the current instruction must visit; stall states repeat.
   int         plan[$];
   logic [5:0] cur_op;
   int         irw_cnt;

   always #5 clk = ~clk;

   multicycle_control dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .Op          (Op),
      .mem_ready   (mem_ready),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .MemtoReg    (MemtoReg),
      .IRWrite     (IRWrite),
      .RegWrite    (RegWrite),
      .RegDst      (RegDst),
      .ALUSrcA     (ALUSrcA),
      .PCSource    (PCSource),
      .ALUSrcB     (ALUSrcB),
      .ALUOp       (ALUOp),
      .state       (state),
      .illegal_op  (illegal_op)
   );

   assign ctrl_obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                      IRWrite, RegWrite, RegDst, ALUSrcA, PCSource, ALUSrcB,
                      ALUOp, illegal_op};

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_legal(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_J);
   endfunction

   // Control vector the state table requires for one cycle.
   function automatic logic [16:0] exp_ctrl(input int st, input bit mr, input logic [5:0] op);
      logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, srca, ill;
      logic [1:0] pcs, srcb, aop;
      {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, srca, ill} = '0;
      pcs = 2'b00; srcb = 2'b00; aop = 2'b00;
      case (st)
         0: begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
         1: begin srcb = 2'b11; ill = !is_legal(op); end
         2: begin srca = 1; srcb = 2'b10; end
         3: begin mrd = 1; iord = 1; end
         4: begin rw = 1; m2r = 1; end
         5: begin mwr = 1; iord = 1; end
         6: begin srca = 1; aop = 2'b10; end
         7: begin rw = 1; rdst = 1; end
         8: begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
         9: begin pcw = 1; pcs = 2'b10; end
         default: ;
      endcase
      return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, srca, pcs, srcb, aop, ill};
   endfunction

   task automatic load_instr(input logic [5:0] op);
      cur_op  = op;
      Op      = op;
      irw_cnt = 0;
      plan.delete();
      plan.push_back(0);
      plan.push_back(1);
      case (op)
         OP_RTYPE: begin plan.push_back(6); plan.push_back(7); end
         OP_LW:    begin plan.push_back(2); plan.push_back(3); plan.push_back(4); end
         OP_SW:    begin plan.push_back(2); plan.push_back(5); end
         OP_BEQ:   plan.push_back(8);
         OP_J:     plan.push_back(9);
         default:  ;
      endcase
   endtask

   task automatic cycle(input bit mr);
      int st;
      mem_ready = mr;
      st = plan[0];
      @(negedge clk);
      check($sformatf("state op=%0d", cur_op), 32'(state), st);
      check($sformatf("ctrl st=%0d mr=%0b op=%0d", st, mr, cur_op), 32'(ctrl_obs),
            32'(exp_ctrl(st, mr, cur_op)));
      if (IRWrite) irw_cnt++;
      @(posedge clk);
      #1;
      if ((st == 0 || st == 3 || st == 5) && !mr) begin
         // memory not ready: the same state repeats
      end else begin
         void'(plan.pop_front());
      end
      if (plan.size() == 0)
         check($sformatf("irwrite_pulses op=%0d", cur_op), 32'(irw_cnt), 1);
   endtask

   task automatic run_instr(input logic [5:0] op);
      load_instr(op);
      while (plan.size() != 0) cycle(1'b1);
   endtask

   task automatic do_reset(input int n);
      int es;
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         es = (i == 0 && plan.size() != 0) ? plan[0] : 0;
         @(negedge clk);
         check("rst_state", 32'(state), es);
         check("rst_ctrl", 32'(ctrl_obs), 0);
         @(posedge clk);
         #1;
      end
      plan.delete();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [5:0] op;
      rst_n     = 1'b0;
      Op        = OP_RTYPE;
      mem_ready = 1'b1;
      cur_op    = OP_RTYPE;
      @(posedge clk);
      #1;
      do_reset(2);

      // R-type with memory always ready.
      run_instr(OP_RTYPE);

      // Reset held three cycles while sitting in EXEC, then resume.
      load_instr(OP_RTYPE);
      cycle(1'b1);
      cycle(1'b1);
      do_reset(3);
      run_instr(OP_RTYPE);

      // lw: two FETCH stalls and three MEMRD stalls -> ten cycles.
      load_instr(OP_LW);
      cycle(1'b0); cycle(1'b0); cycle(1'b1);
      cycle(1'b1); cycle(1'b1);
      cycle(1'b0); cycle(1'b0); cycle(1'b0); cycle(1'b1);
      cycle(1'b1);
      check("lw_ten_cycles_done", 32'(plan.size() == 0), 1);

      // sw (with a MEMWR stall), beq, jump, illegal opcode.
      load_instr(OP_SW);
      cycle(1'b1); cycle(1'b1); cycle(1'b1); cycle(1'b0); cycle(1'b1);
      run_instr(OP_BEQ);
      run_instr(OP_J);
      run_instr(6'h3F);
      run_instr(OP_RTYPE);

      // mem_ready must be ignored outside FETCH/MEMRD/MEMWR.
      load_instr(OP_RTYPE);
      cycle(1'b1); cycle(1'b0); cycle(1'b0); cycle(1'b0);

      // Random instruction stream with random stalls and occasional aborts.
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 5))
            0: op = OP_RTYPE;
            1: op = OP_LW;
            2: op = OP_SW;
            3: op = OP_BEQ;
            4: op = OP_J;
            default: begin
               do op = 6'($urandom_range(0, 63)); while (is_legal(op));
            end
         endcase
         load_instr(op);
         if ($urandom_range(0, 29) == 0) begin
            for (int k = $urandom_range(1, 3); k > 0 && plan.size() != 0; k--)
               cycle($urandom_range(0, 3) != 0);
            do_reset($urandom_range(1, 3));
         end else begin
            while (plan.size() != 0) cycle($urandom_range(0, 3) != 0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
